// File: rtl/hidden_layer_sched.sv
// hidden_layer_sched: time-shares one neuron datapath across a hidden layer; define SCHED_TIMEOUT_EN for a per-neuron RUN watchdog
module hidden_layer_sched #(
  parameter int dataWidth   = 16,
  parameter int fracWidth   = 12,
  parameter int NUM_NEURONS = 15,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        layer_done,
  output logic                        error,
  output logic [ADDR_W-1:0]           w_addr,
  output logic                        neuron_en,
  output logic                        neuron_rst_n,
  input  logic                        neuron_done,
  input  logic signed [2*dataWidth:0] neuron_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [dataWidth-1:0]        out_data,
  output logic [ADDR_W-1:0]           out_idx
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, EMIT, FINISH} state_t;
  localparam logic signed [2*dataWidth:0] MAX_V = {{(dataWidth+2){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [2*dataWidth:0] MIN_V = {{(dataWidth+2){1'b1}}, {(dataWidth-1){1'b0}}};
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic first, accept, capture, timeout;
  logic [dataWidth-1:0] sat;
  // reject configurations the index or result formats cannot represent
  if ((2**ADDR_W) < NUM_NEURONS) begin : g_addr_chk
    $error("ADDR_W too narrow for NUM_NEURONS");
  end
  if (fracWidth >= dataWidth || TIMEOUT < 2) begin : g_fmt_chk
    $error("fracWidth must be below dataWidth and TIMEOUT at least 2");
  end
  assign accept  = state == IDLE && start;
  assign capture = state == RUN && neuron_done && !first;
  assign sat = neuron_result > MAX_V ? {1'b0, {(dataWidth-1){1'b1}}} :
               neuron_result < MIN_V ? {1'b1, {(dataWidth-1){1'b0}}} :
               neuron_result[dataWidth-1:0];
`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] run_cnt;
  logic err;
  assign timeout = state == RUN && !capture && run_cnt == TW'(TIMEOUT - 1);
  assign error = err;
  // RUN-cycle watchdog and sticky error, cleared by the next accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_cnt <= '0;
      err     <= 1'b0;
    end else begin
      run_cnt <= state == RUN ? run_cnt + 1'b1 : '0;
      err     <= accept ? 1'b0 : (timeout ? 1'b1 : err);
    end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif
  // state, neuron index, stale-done mask and captured result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      first    <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      state <= state_nx;
      first <= state == LOAD;
      if (accept) idx <= '0;
      else if (state == EMIT && out_ready && idx != LAST) idx <= idx + 1'b1;
      if (capture) begin
        out_data <= sat;
        out_idx  <= idx;
      end
    end
  // next-state and Moore outputs
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = RUN;
      RUN:     state_nx = capture ? EMIT : (timeout ? FINISH : RUN);
      EMIT:    state_nx = !out_ready ? EMIT : (idx == LAST ? FINISH : LOAD);
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy         = state == LOAD || state == RUN || state == EMIT;
    layer_done   = state == FINISH;
    w_addr       = state == IDLE ? '0 : idx;
    neuron_en    = state == RUN;
    neuron_rst_n = state != LOAD;
    out_valid    = state == EMIT;
  end
endmodule

// File: tb/tb_hidden_layer_sched.sv
// tb_hidden_layer_sched: directed bench with a 37-cycle neuron datapath model
module tb_hidden_layer_sched;
  logic clk, rst, start, busy, layer_done, error, neuron_en, neuron_rst_n, neuron_done;
  logic out_valid, out_ready;
  logic [1:0] w_addr, out_idx;
  logic [15:0] out_data;
  logic signed [32:0] nres;
  logic signed [32:0] res [0:3];
  int dcnt, hang_idx, n_chk, n_fail, ld_cnt, cyc;
  logic [15:0] q_data[$];
  logic [1:0] q_idx[$];

  hidden_layer_sched #(.dataWidth(16), .fracWidth(12), .NUM_NEURONS(3), .ADDR_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .layer_done(layer_done), .error(error),
    .w_addr(w_addr), .neuron_en(neuron_en), .neuron_rst_n(neuron_rst_n), .neuron_done(neuron_done),
    .neuron_result(nres), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: done once 37 enabled cycles have elapsed since clear
  always @(posedge clk or posedge rst)
    if (rst) dcnt <= 0;
    else if (!neuron_rst_n) dcnt <= 0;
    else if (neuron_en) dcnt <= dcnt + 1;
  assign neuron_done = dcnt >= 37 && int'(w_addr) != hang_idx;
  assign nres = res[w_addr];

  // record stream transfers and layer_done pulses
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_idx.push_back(out_idx);
    end
    if (layer_done) ld_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cyc counts edges from the start-sampling edge through the edge that samples layer_done
  task automatic pass(output int c);
    bit seen;
    seen = 0;
    c = 0;
    start = 1;
    while (!seen && c < 3000) begin
      @(posedge clk);
      c++;
      #1;
      if (c == 1) begin
        start = 0;
        check("load_busy", busy, 1);
        check("load_rstn", neuron_rst_n, 0);
        check("load_en", neuron_en, 0);
      end
      if (c == 2) begin
        check("run_en", neuron_en, 1);
        check("run_rstn", neuron_rst_n, 1);
      end
      seen = layer_done;
    end
    if (!seen) check("pass_timeout", 0, 1);
    else begin
      @(posedge clk);
      c++;
      #1;
      check("ld_one_cycle", layer_done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic expect_xfers(input int base, input int n, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] e [3];
    e = '{e0, e1, e2};
    check("xfer_count", q_data.size() - base, n);
    for (int i = 0; i < n && base + i < q_data.size(); i++) begin
      check($sformatf("xfer_data%0d", i), q_data[base+i], e[i]);
      check($sformatf("xfer_idx%0d", i), q_idx[base+i], i);
    end
  endtask

  task automatic wait_run1(input int a);
    int k;
    k = 0;
    while (!(w_addr == 2'(a) && neuron_en) && k < 500) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 500) check("wait_run", 0, 1);
  endtask

  initial begin
    int base, ld0, k;
    n_chk = 0; n_fail = 0; ld_cnt = 0; hang_idx = -1;
    rst = 1; start = 0; out_ready = 1;
    res[0] = 33'h0_0000_1000; res[1] = 33'h0_0000_0800; res[2] = 33'h1_FFFF_F000; res[3] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld", layer_done, 0);
    check("rst_err", error, 0);
    check("rst_waddr", w_addr, 0);
    check("rst_en", neuron_en, 0);
    check("rst_rstn", neuron_rst_n, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    rst = 0;
    @(posedge clk);
    #1;
    // basic pass
    base = q_data.size(); ld0 = ld_cnt;
    pass(cyc);
    check("pass_cycles", cyc, 122);
    expect_xfers(base, 3, 16'h1000, 16'h0800, 16'hF000);
    check("ld_count", ld_cnt - ld0, 1);
    check("err_clear", error, 0);
    // saturation
    res[0] = 33'h0_0000_9000; res[1] = 33'h1_FFFF_0000; res[2] = 33'h0_0000_0123;
    base = q_data.size();
    pass(cyc);
    expect_xfers(base, 3, 16'h7FFF, 16'h8000, 16'h0123);
    // back-pressure at neuron 1
    res[0] = 33'h0_0000_1000; res[1] = 33'h0_0000_0800; res[2] = 33'h1_FFFF_F000;
    base = q_data.size();
    fork
      pass(cyc);
      begin
        wait_run1(1);
        out_ready = 0;
        k = 0;
        while (!out_valid && k < 500) begin
          @(posedge clk);
          #2;
          k++;
        end
        for (int i = 0; i < 10; i++) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, 16'h0800);
          check("stall_idx", out_idx, 1);
          check("stall_en", neuron_en, 0);
          @(posedge clk);
          #2;
        end
        out_ready = 1;
      end
    join
    check("stall_cycles", cyc, 132);
    expect_xfers(base, 3, 16'h1000, 16'h0800, 16'hF000);
    // start during RUN of neuron 1 is ignored
    base = q_data.size(); ld0 = ld_cnt;
    fork
      pass(cyc);
      begin
        wait_run1(1);
        start = 1;
        @(posedge clk);
        #2;
        start = 0;
      end
    join
    check("ign_cycles", cyc, 122);
    expect_xfers(base, 3, 16'h1000, 16'h0800, 16'hF000);
    check("ign_ld_count", ld_cnt - ld0, 1);
    // asynchronous reset mid-RUN of neuron 2
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_run1(2);
    rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ld", layer_done, 0);
    check("arst_err", error, 0);
    check("arst_waddr", w_addr, 0);
    check("arst_en", neuron_en, 0);
    check("arst_rstn", neuron_rst_n, 1);
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_idx", out_idx, 0);
    @(negedge clk);
    rst = 0;
    base = q_data.size();
    pass(cyc);
    check("restart_cycles", cyc, 122);
    expect_xfers(base, 3, 16'h1000, 16'h0800, 16'hF000);
`ifdef SCHED_TIMEOUT_EN
    // watchdog abort at neuron 1
    hang_idx = 1;
    base = q_data.size(); ld0 = ld_cnt;
    pass(cyc);
    check("to_cycles", cyc, 107);
    expect_xfers(base, 1, 16'h1000, 16'h0000, 16'h0000);
    check("to_ld_count", ld_cnt - ld0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", error, 1);
    hang_idx = -1;
    base = q_data.size();
    pass(cyc);
    check("to_err_cleared", error, 0);
    expect_xfers(base, 3, 16'h1000, 16'h0800, 16'hF000);
`else
    check("err_const", error, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
